// File: rtl/sprite_fetch_dispatcher.sv
// sprite_fetch_dispatcher
//   Upstream feeder for the stream_processor tile array. Accepts one
//   sprite-draw command per valid/ready handshake, fetches the sprite's two
//   16-byte texture rows from synchronous texture memory, and broadcasts
//   rows, start x and depth to the array with a single-cycle o_ena pulse.
//   Only one command is in flight at a time.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   i_cmd_valid         command valid
//   o_cmd_ready         high only in IDLE
//   i_cmd_tex_addr      word address of row 0 (row 1 at the next word)
//   i_cmd_start_x       first tile column of the sprite
//   i_cmd_z             sprite depth
//   o_mem_rd_en         texture read strobe
//   o_mem_addr          texture read address
//   i_mem_rdata         read data, RD_LATENCY cycles after its strobe
//   o_ena               one-cycle broadcast pulse
//   o_texture_data      {row 1, row 0}
//   o_start_x           broadcast start x
//   o_position_z        broadcast depth
//   o_busy              high whenever not IDLE
module sprite_fetch_dispatcher #(
  parameter int TEX_AW     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [TEX_AW-1:0] i_cmd_tex_addr,
  input  logic [3:0]        i_cmd_start_x,
  input  logic [7:0]        i_cmd_z,
  output logic              o_mem_rd_en,
  output logic [TEX_AW-1:0] o_mem_addr,
  input  logic [127:0]      i_mem_rdata,
  output logic              o_ena,
  output logic [255:0]      o_texture_data,
  output logic [3:0]        o_start_x,
  output logic [7:0]        o_position_z,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    WAIT,
    BCAST
  } state_t;

  state_t              state;
  logic [TEX_AW-1:0]   cmd_addr;
  logic [3:0]          cmd_start_x;
  logic [7:0]          cmd_z;
  logic [127:0]        row0_sh;

  // Read-tag pipeline: stage RD_LATENCY-1 lines up with i_mem_rdata.
  logic [RD_LATENCY-1:0] tag_v;
  logic [RD_LATENCY-1:0] tag_row;

  logic tag_out_v;
  logic tag_out_row;

  assign tag_out_v   = tag_v[RD_LATENCY-1];
  assign tag_out_row = tag_row[RD_LATENCY-1];

  assign o_busy      = (state != IDLE);
  assign o_cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cmd_addr       <= '0;
      cmd_start_x    <= '0;
      cmd_z          <= '0;
      row0_sh        <= '0;
      tag_v          <= '0;
      tag_row        <= '0;
      o_mem_rd_en    <= 1'b0;
      o_mem_addr     <= '0;
      o_ena          <= 1'b0;
      o_texture_data <= '0;
      o_start_x      <= '0;
      o_position_z   <= '0;
    end else begin
      o_ena       <= 1'b0;
      o_mem_rd_en <= 1'b0;

      // The strobe is registered, so while it is high the state is RD0/RD1
      // and identifies which row the read belongs to.
      tag_v[0]   <= o_mem_rd_en;
      tag_row[0] <= (state == RD1);
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_row[i] <= tag_row[i-1];
      end

      // Row 1 goes straight into the broadcast register in WAIT, so only
      // row 0 needs a shadow copy.
      if (tag_out_v && !tag_out_row) begin
        row0_sh <= i_mem_rdata;
      end

      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            cmd_addr    <= i_cmd_tex_addr;
            cmd_start_x <= i_cmd_start_x;
            cmd_z       <= i_cmd_z;
            o_mem_rd_en <= 1'b1;
            o_mem_addr  <= i_cmd_tex_addr;
            state       <= RD0;
          end
        end
        RD0: begin
          o_mem_rd_en <= 1'b1;
          o_mem_addr  <= cmd_addr + TEX_AW'(1);
          state       <= RD1;
        end
        RD1: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tag_out_v && tag_out_row) begin
            o_texture_data <= {i_mem_rdata, row0_sh};
            o_start_x      <= cmd_start_x;
            o_position_z   <= cmd_z;
            o_ena          <= 1'b1;
            state          <= BCAST;
          end
        end
        BCAST: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch_dispatcher.sv
module tb_sprite_fetch_dispatcher;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: RD_LATENCY=1, index 1: RD_LATENCY=3
  logic         valid   [2];
  logic         ready   [2];
  logic [9:0]   addr_in [2];
  logic [3:0]   sx_in   [2];
  logic [7:0]   z_in    [2];
  logic         rd_en   [2];
  logic [9:0]   mem_addr[2];
  logic [127:0] rdata   [2];
  logic         ena     [2];
  logic [255:0] tex     [2];
  logic [3:0]   sx_out  [2];
  logic [7:0]   z_out   [2];
  logic         busy    [2];

  sprite_fetch_dispatcher #(.TEX_AW(10), .RD_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_valid(valid[0]), .o_cmd_ready(ready[0]),
    .i_cmd_tex_addr(addr_in[0]), .i_cmd_start_x(sx_in[0]), .i_cmd_z(z_in[0]),
    .o_mem_rd_en(rd_en[0]), .o_mem_addr(mem_addr[0]), .i_mem_rdata(rdata[0]),
    .o_ena(ena[0]), .o_texture_data(tex[0]), .o_start_x(sx_out[0]),
    .o_position_z(z_out[0]), .o_busy(busy[0]));

  sprite_fetch_dispatcher #(.TEX_AW(10), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_valid(valid[1]), .o_cmd_ready(ready[1]),
    .i_cmd_tex_addr(addr_in[1]), .i_cmd_start_x(sx_in[1]), .i_cmd_z(z_in[1]),
    .o_mem_rd_en(rd_en[1]), .o_mem_addr(mem_addr[1]), .i_mem_rdata(rdata[1]),
    .o_ena(ena[1]), .o_texture_data(tex[1]), .o_start_x(sx_out[1]),
    .o_position_z(z_out[1]), .o_busy(busy[1]));

  // Texture memory model: random garbage on the bus except RD_LATENCY
  // cycles after a strobe.
  logic [127:0] mem [1024];
  logic [127:0] p0;
  logic [127:0] p3 [3];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(posedge clk) begin
    p0    <= rd_en[0] ? mem[mem_addr[0]] : rnd128();
    p3[0] <= rd_en[1] ? mem[mem_addr[1]] : rnd128();
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata[0] = p0;
  assign rdata[1] = p3[2];

  int checks = 0;
  int errors = 0;

  logic [255:0] last_tex [2];
  logic [3:0]   last_sx  [2];
  logic [7:0]   last_z   [2];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command on DUT s; checks every cycle until ready returns.
  task automatic do_cmd(input int s, input logic [9:0] a, input logic [3:0] sx, input logic [7:0] z);
    int lat;
    int n;
    logic [9:0] a1;
    logic [255:0] exp_tex;
    lat = (s == 0) ? 1 : 3;
    a1 = a + 10'd1;
    exp_tex = {mem[a1], mem[a]};
    @(negedge clk);
    n = 0;
    while (!ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", ready[s], 1'b1);
    valid[s] = 1'b1; addr_in[s] = a; sx_in[s] = sx; z_in[s] = z;
    @(posedge clk);
    #1 valid[s] = 1'b0;
    addr_in[s] = 10'($urandom); sx_in[s] = 4'($urandom); z_in[s] = 8'($urandom);
    for (int c = 1; c <= 4 + lat; c++) begin
      @(negedge clk);
      chk("rd_en", rd_en[s], (c == 1 || c == 2));
      if (c == 1) chk("rd_addr0", mem_addr[s], a);
      if (c == 2) chk("rd_addr1", mem_addr[s], a1);
      chk("ena", ena[s], (c == 3 + lat));
      chk("busy", busy[s], (c < 4 + lat));
      chk("ready", ready[s], (c >= 4 + lat));
      if (c < 3 + lat) begin
        chk("tex_hold", tex[s], last_tex[s]);
        chk("sx_hold", sx_out[s], last_sx[s]);
        chk("z_hold", z_out[s], last_z[s]);
      end else begin
        chk("tex", tex[s], exp_tex);
        chk("start_x", sx_out[s], sx);
        chk("pos_z", z_out[s], z);
      end
    end
    last_tex[s] = exp_tex; last_sx[s] = sx; last_z[s] = z;
  endtask

  initial begin
    logic [255:0] ta, tb;
    for (int i = 0; i < 1024; i++) mem[i] = rnd128();
    for (int n = 0; n < 16; n++) begin
      mem[5][8*n +: 8] = 8'(n + 1);
      mem[6][8*n +: 8] = 8'(n + 17);
    end
    for (int s = 0; s < 2; s++) begin
      valid[s] = 1'b0; addr_in[s] = '0; sx_in[s] = '0; z_in[s] = '0;
      last_tex[s] = '0; last_sx[s] = '0; last_z[s] = '0;
    end

    // reset
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ena", ena[s], 1'b0);
      chk("rst_rd_en", rd_en[s], 1'b0);
      chk("rst_addr", mem_addr[s], 10'd0);
      chk("rst_tex", tex[s], '0);
      chk("rst_busy", busy[s], 1'b0);
      chk("rst_ready", ready[s], 1'b1);
    end
    reset_n = 1'b1;

    // directed first command at latency 1
    do_cmd(0, 10'h005, 4'd3, 8'h40);
    chk("byte0_row0", tex[0][7:0], 8'h01);
    chk("byte0_row1", tex[0][135:128], 8'h11);

    // address wrap on both latencies; latency-3 row placement
    do_cmd(0, 10'h3FF, 4'd9, 8'h00);
    do_cmd(1, 10'h3FF, 4'd1, 8'h7E);
    do_cmd(1, 10'h005, 4'd15, 8'hFF);
    chk("lat3_byte0_row1", tex[1][135:128], 8'h11);

    // back-to-back at latency 1, valid held high
    ta = {mem[10'h101], mem[10'h100]};
    tb = {mem[10'h201], mem[10'h200]};
    @(negedge clk);
    valid[0] = 1'b1; addr_in[0] = 10'h100; sx_in[0] = 4'd2; z_in[0] = 8'h11;
    @(posedge clk);
    #1 addr_in[0] = 10'h200; sx_in[0] = 4'd7; z_in[0] = 8'h22;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("b2b_ena", ena[0], (c == 4 || c == 9));
      chk("b2b_ready", ready[0], (c == 5 || c == 10));
      chk("b2b_tex", tex[0], (c < 4) ? last_tex[0] : (c < 9) ? ta : tb);
      chk("b2b_sx", sx_out[0], (c < 4) ? last_sx[0] : (c < 9) ? 4'd2 : 4'd7);
      if (c == 5) begin
        @(posedge clk);
        #1 valid[0] = 1'b0;
      end
    end
    last_tex[0] = tb; last_sx[0] = 4'd7; last_z[0] = 8'h22;

    // randomized commands against the model
    for (int k = 0; k < 12; k++) begin
      int s;
      s = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_cmd(s, 10'($urandom), 4'($urandom), 8'($urandom));
    end

    // reset asserted during WAIT on latency-3 instance
    @(negedge clk);
    valid[1] = 1'b1; addr_in[1] = 10'h033; sx_in[1] = 4'd5; z_in[1] = 8'h99;
    @(posedge clk);
    #1 valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy[1], 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tex", tex[1], '0);
    chk("mid_rst_z", z_out[1], 8'h00);
    chk("mid_rst_busy", busy[1], 1'b0);
    chk("mid_rst_ena", ena[1], 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      last_tex[s] = '0; last_sx[s] = '0; last_z[s] = '0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_ena", ena[1], 1'b0);
      chk("post_rst_ready", ready[1], 1'b1);
      chk("post_rst_tex", tex[1], '0);
    end

    // idle with valid low
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("idle_rd_en", rd_en[s], 1'b0);
        chk("idle_ena", ena[s], 1'b0);
        chk("idle_busy", busy[s], 1'b0);
      end
    end

    do_cmd(1, 10'h2AA, 4'd4, 8'h0C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_dispatcher.md
Name: sprite_fetch_dispatcher

Overview:
- Upstream feeder for the 16x2 stream_processor tile array.
- Accepts one sprite-draw command per valid/ready handshake and fetches the sprite's two 16-byte texture rows from synchronous texture memory.
- Broadcasts the rows, start x and depth to every processor with a single-cycle enable pulse.
- One command in flight at a time.

Parameters:
TEX_AW, 10, texture memory word-address width; one word is one 16-byte row
RD_LATENCY, 1, texture memory read latency in cycles; legal range 1..4

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid and ready are both high on a rising edge
i_cmd_tex_addr  in  TEX_AW  word address of texture row 0; row 1 is at the next word
i_cmd_start_x  in  4  first tile column covered by the sprite
i_cmd_z  in  8  sprite depth
o_mem_rd_en  out  1  texture read strobe
o_mem_addr  out  TEX_AW  texture read address
i_mem_rdata  in  128  read data, valid RD_LATENCY cycles after its strobe cycle
o_ena  out  1  one-cycle broadcast pulse to the processor array
o_texture_data  out  256  bits [127:0] = row 0, bits [255:128] = row 1; byte n of a row at bits [8n+7:8n]
o_start_x  out  4  broadcast start x
o_position_z  out  8  broadcast depth
o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset state: all outputs 0; state IDLE; read-tag pipeline cleared.
- Reset is asynchronous. Asserting it mid-operation abandons the command, discards in-flight reads and returns to IDLE. Late read data arriving after reset release is ignored.
- States: IDLE, RD0, RD1, WAIT, BCAST.
- IDLE:
  - o_cmd_ready = 1 (combinational from state). Only IDLE asserts ready.
  - On handshake: latch address, start_x and z; go to RD0.
- RD0: o_mem_rd_en = 1, o_mem_addr = latched address; go to RD1.
- RD1:
  - o_mem_rd_en = 1, o_mem_addr = latched address + 1, truncated to TEX_AW bits (address 2^TEX_AW-1 wraps to 0).
  - Go to WAIT.
- Read tracking: a RD_LATENCY-deep shift register carries tags {valid, row}. When a tag emerges, i_mem_rdata is captured into the shadow row-0 or row-1 register.
- WAIT: when the row-1 tag emerges, capture row 1 and go to BCAST in the same edge. Row 1 always arrives after row 0.
- BCAST:
  - o_ena = 1 for exactly one cycle.
  - o_texture_data, o_start_x and o_position_z are loaded from the shadow registers and latched command on the edge entering BCAST.
  - Go to IDLE.
- Broadcast outputs hold their value until the next BCAST. Shadow registers may change underneath without affecting the outputs.
- Latency: command accepted at edge of cycle 0; o_ena high in cycle 3+RD_LATENCY (cycle 4 for default); o_cmd_ready high again in cycle 4+RD_LATENCY. Peak throughput is one sprite per 4+RD_LATENCY cycles.
- o_mem_rd_en is never high outside RD0/RD1.
- i_cmd_valid low or inputs changing while not ready: ignored, no state change.
- Zero texture bytes are passed through unchanged. Transparency and the z==0 override are the processor's job.
- o_busy = (state != IDLE); o_cmd_ready = !o_busy.

Test Plan:
- Reset, then cmd addr=0x005, start_x=3, z=0x40; mem returns row0 bytes 0x01..0x10, row1 0x11..0x20 at RD_LATENCY=1 -> rd_en at addr 0x005 in cycle 1 and 0x006 in cycle 2. Required response: o_ena pulse in cycle 4 only; o_texture_data[7:0]=0x01, [135:128]=0x11; o_start_x=3; o_position_z=0x40.
- Back-to-back: valid held high with two commands -> second accepted exactly in cycle 5. Required response: two o_ena pulses 5 cycles apart; outputs stable between pulses.
- Address wrap: addr=0x3FF, TEX_AW=10 -> reads at 0x3FF then 0x000.
- RD_LATENCY=3 build -> o_ena in cycle 6; rows captured in the correct halves; rdata garbage in non-tag cycles ignored.
- Assert reset_n low during WAIT -> outputs drop to 0 immediately. Required response: after release, state IDLE, ready=1, no o_ena pulse from the stale read data.
- Valid low in IDLE for 20 cycles -> no rd_en, no o_ena, o_busy=0.
